bp_stall_histogram: RTL and testbench
=====================================

# bp_stall_histogram

Synthesizable per-core stall-cycle histogram that sits directly downstream of the core stall profiler. Each unfrozen cycle it consumes one classified event: either an instruction retired, or a 6-bit stall-reason code. It accumulates the events into a bank of saturating counters. A single-outstanding request/response read port and a synchronous clear let host software (through the shell's CSR bridge) read the bins without halting the core.

## Interface
Parameters:
- ctr_width_p, 32, width of every bin counter
- num_reasons_p, 33, number of stall-reason codes (0..32, where 0 = unknown)
- addr_width_p, 6, read-address width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset; asynchronous, active-low
- v_i  in  1  event valid (core out of reset and not frozen)
- instret_i  in  1  an instruction committed this cycle
- stall_reason_i  in  6  stall_reason_e code; ignored when instret_i=1
- clear_i  in  1  synchronous clear of all bins and overflow_o
- req_v_i  in  1  read request valid
- req_addr_i  in  addr_width_p  bin index
- req_ready_o  out  1  read request accepted when req_v_i & req_ready_o
- resp_v_o  out  1  read response valid
- resp_data_o  out  ctr_width_p  bin value
- resp_ready_i  in  1  response consumed when resp_v_o & resp_ready_i
- overflow_o  out  1  sticky; set when any bin saturates

## Operation
- Bin map:
  - 0..32: stall reasons, indexed by code.
  - 33: instr (retired instructions).
  - 34: total cycles (every cycle with v_i=1).
  - Bins 35 and above are not implemented.
- For each cycle with v_i=1:
  - Bin 34 increments.
  - If instret_i=1, bin 33 increments.
  - Otherwise, the bin for stall_reason_i increments. A code >32 is counted in bin 0 (unknown).
- v_i=0: no bin changes.
- Saturation: a bin at 2^ctr_width_p-1 holds its value. Any increment attempted at that value sets overflow_o.
- clear_i=1: all bins and overflow_o are 0 after the edge. Clear wins over a same-cycle increment; that event is dropped.
- Read port:
  - One-entry response register.
  - req_ready_o = ~resp_v_o | resp_ready_i.
  - On acceptance, the response register loads the addressed bin's next-state value, so it includes the event sampled in the same cycle (or 0 if clear_i=1 that cycle).
  - Address >34 returns 0.
  - resp_data_o stays stable while resp_v_o=1 and resp_ready_i=0.
- Reset: all bins = 0, overflow_o = 0, resp_v_o = 0, resp_data_o = 0. req_ready_o = 1 combinationally once out of reset.

## Timing
- Event in cycle t is visible in the bin register at t+1.
- Read accepted in cycle t gives resp_v_o=1 at t+1. Latency 1; throughput 1 read per cycle when resp_ready_i is held high.
- resp_v_o deasserts the cycle after a consume with no new accept.
- Back-to-back accept and consume in the same cycle: the response register reloads and resp_v_o stays 1.
- clear_i together with a read accept: the response returns 0.
- reset_n_i asserted mid-transaction: the response is discarded asynchronously and resp_v_o=0 immediately. Counters clear; there is no partial-count retention.
- No combinational path from req_v_i/req_addr_i to resp_*. The only combinational path is resp_ready_i to req_ready_o.

## Structure
- Shared package bp_stall_pkg contains:
  - stall_reason_e, the 6-bit enum with codes 0..32.
  - Bin constants: instr bin = 33, cycle bin = 34, num_bins = 35.
- Sub-module bp_stall_sat_counter: one saturating counter with inputs up_i and clear_i, outputs count_o, count_n_o and sat_o. It is instantiated num_bins times via generate.
- Top level contains:
  - one-hot bin-select decode;
  - next-state read mux (count_n_o) feeding the response register;
  - overflow OR-reduce.

## Test plan
- Reset: after reset_n_i is released, read bins 0, 33, 34 → 0, 0, 0; overflow_o=0; req_ready_o=1.
- Event counts: with v_i=1, send 10 cycles of instret, then 5 cycles of code 6 (dcache_miss), then 3 cycles of code 40. Reads must return bin33=10, bin6=5, bin0=3, bin34=18. Cycles with v_i=0 add nothing.
- Same-cycle read and event: a read of bin 6 in the same cycle as a code-6 event returns the old value+1 at t+1. With clear_i asserted in that cycle instead, the read returns 0 and bin 34 reads 0 afterwards.
- Backpressure: with resp_ready_i=0 for 4 cycles, resp_data_o stays stable and req_ready_o=0. With resp_ready_i=1 and req_v_i held, one response is issued per cycle. Reading address 50 returns 0.
- Saturation: with ctr_width_p=4, 20 code-1 events leave bin1=15 and overflow_o=1. clear_i then returns bin1=0 and overflow_o=0.
- Asynchronous reset: assert reset_n_i low mid-cycle while resp_v_o=1. resp_v_o must drop with no clock edge, and all bins must read 0 afterwards.

Source files
------------

// File: rtl/bp_stall_pkg.sv
// rtl/bp_stall_pkg.sv - shared stall-reason codes and bin map for the stall histogram
package bp_stall_pkg;

  localparam int num_reasons_c = 33;
  localparam int instr_bin_c   = 33;
  localparam int cycle_bin_c   = 34;
  localparam int num_bins_c    = 35;

  typedef enum logic [5:0] {
    sr_unknown          = 6'd0,
    sr_icache_miss      = 6'd1,
    sr_itlb_miss        = 6'd2,
    sr_branch_mispred   = 6'd3,
    sr_fetch_bubble     = 6'd4,
    sr_decode_stall     = 6'd5,
    sr_dcache_miss      = 6'd6,
    sr_dtlb_miss        = 6'd7,
    sr_lsq_full         = 6'd8,
    sr_store_buf_full   = 6'd9,
    sr_rob_full         = 6'd10,
    sr_iq_full          = 6'd11,
    sr_int_dep          = 6'd12,
    sr_fp_dep           = 6'd13,
    sr_mul_busy         = 6'd14,
    sr_div_busy         = 6'd15,
    sr_fpu_busy         = 6'd16,
    sr_fence            = 6'd17,
    sr_amo              = 6'd18,
    sr_csr              = 6'd19,
    sr_exception        = 6'd20,
    sr_interrupt        = 6'd21,
    sr_replay           = 6'd22,
    sr_mem_order        = 6'd23,
    sr_l2_miss          = 6'd24,
    sr_coherence        = 6'd25,
    sr_uncached         = 6'd26,
    sr_ptw_busy         = 6'd27,
    sr_sfence           = 6'd28,
    sr_wfi              = 6'd29,
    sr_debug            = 6'd30,
    sr_rename_full      = 6'd31,
    sr_commit_stall     = 6'd32
  } stall_reason_e;

endpackage

// File: rtl/bp_stall_histogram_if.sv
// rtl/bp_stall_histogram_if.sv - request/response read port of the stall histogram
interface bp_stall_histogram_if #(
  parameter int addr_width_p = 6,
  parameter int ctr_width_p  = 32
);
  logic                    req_v_i;
  logic [addr_width_p-1:0] req_addr_i;
  logic                    req_ready_o;
  logic                    resp_v_o;
  logic [ctr_width_p-1:0]  resp_data_o;
  logic                    resp_ready_i;

  modport master (
    output req_v_i, req_addr_i, resp_ready_i,
    input  req_ready_o, resp_v_o, resp_data_o
  );

  modport slave (
    input  req_v_i, req_addr_i, resp_ready_i,
    output req_ready_o, resp_v_o, resp_data_o
  );
endinterface

// File: rtl/bp_stall_sat_counter.sv
// rtl/bp_stall_sat_counter.sv - one saturating bin counter with synchronous clear
module bp_stall_sat_counter #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               up_i,
  input  logic               clear_i,
  output logic [width_p-1:0] count_o,
  output logic [width_p-1:0] count_n_o,
  output logic               sat_o
);

  logic full;
  assign full  = &count_o;
  // an increment attempted while already at the ceiling
  assign sat_o = up_i & full;

  // next value: clear beats increment, ceiling holds
  always_comb begin
    count_n_o = count_o;
    if (clear_i)
      count_n_o = '0;
    else if (up_i && !full)
      count_n_o = count_o + 1'b1;
  end

  // count register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) count_o <= '0;
    else            count_o <= count_n_o;
  end

endmodule

// File: rtl/bp_stall_histogram.sv
// rtl/bp_stall_histogram.sv - per-core stall-cycle histogram with single-outstanding read port
module bp_stall_histogram
  import bp_stall_pkg::*;
#(
  parameter int ctr_width_p   = 32,
  parameter int num_reasons_p = num_reasons_c,
  parameter int addr_width_p  = 6
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 v_i,
  input  logic                 instret_i,
  input  logic [5:0]           stall_reason_i,
  input  logic                 clear_i,
  output logic                 overflow_o,
  bp_stall_histogram_if.slave  rd
);

  // reason bins first, then retired-instruction bin, then total-cycle bin
  localparam int nb = num_reasons_p + 2;

  logic [nb-1:0]          up;
  logic [nb-1:0]          sat;
  logic [ctr_width_p-1:0] count_q [nb];
  logic [ctr_width_p-1:0] count_n [nb];
  logic [ctr_width_p-1:0] rd_n;
  logic                   accept;

  // one-hot bin select for the event sampled this cycle
  always_comb begin
    up = '0;
    if (v_i) begin
      up[nb-1] = 1'b1;
      if (instret_i)
        up[nb-2] = 1'b1;
      else if (int'(stall_reason_i) < num_reasons_p)
        up[stall_reason_i] = 1'b1;
      else
        up[0] = 1'b1;
    end
  end

  for (genvar b = 0; b < nb; b++) begin : g_bin
    bp_stall_sat_counter #(.width_p(ctr_width_p)) u_ctr (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .up_i      (up[b]),
      .clear_i   (clear_i),
      .count_o   (count_q[b]),
      .count_n_o (count_n[b]),
      .sat_o     (sat[b])
    );
  end

  // read from next-state values so a same-cycle event or clear is reflected
  always_comb begin
    rd_n = '0;
    if (int'(rd.req_addr_i) < nb)
      rd_n = count_n[rd.req_addr_i];
  end

  // sticky overflow, cleared with the bins
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   overflow_o <= 1'b0;
    else if (clear_i) overflow_o <= 1'b0;
    else if (|sat)    overflow_o <= 1'b1;
  end

  assign rd.req_ready_o = ~rd.resp_v_o | rd.resp_ready_i;
  assign accept         = rd.req_v_i & rd.req_ready_o;

  // one-entry response register; data holds while stalled
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd.resp_v_o    <= 1'b0;
      rd.resp_data_o <= '0;
    end else if (accept) begin
      rd.resp_v_o    <= 1'b1;
      rd.resp_data_o <= rd_n;
    end else if (rd.resp_ready_i) begin
      rd.resp_v_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_stall_histogram.sv
// tb/tb_bp_stall_histogram.sv - self-checking bench for bp_stall_histogram
module tb_bp_stall_histogram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, v, instret, clear, ovf, ovf4;
  logic [5:0] reason;
  bit         use4;
  int         total = 0;
  int         bad   = 0;
  logic [31:0] expq [$];

  bp_stall_histogram_if #(.addr_width_p(6), .ctr_width_p(32)) rd  ();
  bp_stall_histogram_if #(.addr_width_p(6), .ctr_width_p(4))  rd4 ();

  assign rd4.req_v_i      = rd.req_v_i;
  assign rd4.req_addr_i   = rd.req_addr_i;
  assign rd4.resp_ready_i = rd.resp_ready_i;

  bp_stall_histogram #(.ctr_width_p(32), .num_reasons_p(33), .addr_width_p(6)) dut (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .instret_i(instret),
    .stall_reason_i(reason), .clear_i(clear), .overflow_o(ovf), .rd(rd.slave)
  );

  bp_stall_histogram #(.ctr_width_p(4), .num_reasons_p(33), .addr_width_p(6)) dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .instret_i(instret),
    .stall_reason_i(reason), .clear_i(clear), .overflow_o(ovf4), .rd(rd4.slave)
  );

  typedef struct { logic v; logic instret; logic [5:0] code; int reps; } ev_t;
  typedef struct { logic [5:0] addr; logic [31:0] exp; } rd_t;
  ev_t ev_tab [5];
  rd_t rd_tab [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: each response consumed at the next edge is compared once
  always @(negedge clk) begin
    if (rst_n && rd.resp_v_o && rd.resp_ready_i) begin
      if (expq.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        check("resp_data", use4 ? {28'd0, rd4.resp_data_o} : rd.resp_data_o, e);
      end
    end
  end

  task automatic issue(input logic [5:0] a, input logic [31:0] e);
    int n = 0;
    rd.req_v_i    = 1'b1;
    rd.req_addr_i = a;
    while (!rd.req_ready_o && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      check("req_accept_timeout", 32'd0, 32'd1);
    end else begin
      expq.push_back(e);
      step();
    end
    rd.req_v_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (expq.size() != 0) begin
      check("drain_timeout", expq.size(), 0);
      expq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_tab[0] = '{1'b1, 1'b1, 6'd0,  10};
    ev_tab[1] = '{1'b1, 1'b0, 6'd6,  5};
    ev_tab[2] = '{1'b1, 1'b0, 6'd40, 3};
    ev_tab[3] = '{1'b0, 1'b1, 6'd0,  4};
    ev_tab[4] = '{1'b0, 1'b0, 6'd6,  2};
    rd_tab[0] = '{6'd33, 32'd10};
    rd_tab[1] = '{6'd6,  32'd5};
    rd_tab[2] = '{6'd0,  32'd3};
    rd_tab[3] = '{6'd34, 32'd18};
    rd_tab[4] = '{6'd40, 32'd0};
    rd_tab[5] = '{6'd50, 32'd0};
    rd_tab[6] = '{6'd5,  32'd0};

    rst_n = 1'b0; v = 1'b0; instret = 1'b0; reason = '0; clear = 1'b0; use4 = 1'b0;
    rd.req_v_i = 1'b0; rd.req_addr_i = '0; rd.resp_ready_i = 1'b1;

    // reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_resp_v", rd.resp_v_o, 0);
    check("rst_resp_data", rd.resp_data_o, 0);
    check("rst_overflow", ovf, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", rd.req_ready_o, 1);
    issue(6'd0, 0); issue(6'd33, 0); issue(6'd34, 0);
    drain();

    // table-driven event counts and reads
    foreach (ev_tab[i]) begin
      for (int r = 0; r < ev_tab[i].reps; r++) begin
        v = ev_tab[i].v; instret = ev_tab[i].instret; reason = ev_tab[i].code;
        step();
      end
    end
    v = 1'b0;
    foreach (rd_tab[i]) issue(rd_tab[i].addr, rd_tab[i].exp);
    drain();

    // read and event in the same cycle
    v = 1'b1; instret = 1'b0; reason = 6'd6;
    rd.req_v_i = 1'b1; rd.req_addr_i = 6'd6; expq.push_back(32'd6);
    step();
    // clear together with event and read
    clear = 1'b1; expq.push_back(32'd0);
    step();
    clear = 1'b0; v = 1'b0; rd.req_v_i = 1'b0;
    issue(6'd34, 0);
    drain();
    @(negedge clk);
    check("clear_overflow", ovf, 0);

    // backpressure: response held stable while events keep arriving
    v = 1'b1; instret = 1'b1;
    repeat (3) step();
    v = 1'b0;
    rd.resp_ready_i = 1'b0;
    issue(6'd33, 3);
    v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_resp_v", rd.resp_v_o, 1);
      check("bp_resp_data", rd.resp_data_o, 3);
      check("bp_req_ready", rd.req_ready_o, 0);
      step();
    end
    v = 1'b0;
    rd.resp_ready_i = 1'b1;
    drain();
    // streaming reads, one per cycle
    rd.req_v_i = 1'b1;
    rd.req_addr_i = 6'd33; expq.push_back(32'd7); step();
    rd.req_addr_i = 6'd34; expq.push_back(32'd7); step();
    rd.req_addr_i = 6'd50; expq.push_back(32'd0); step();
    rd.req_addr_i = 6'd0;  expq.push_back(32'd0); step();
    rd.req_v_i = 1'b0;
    @(negedge clk);
    #1;
    check("stream_throughput", expq.size(), 0);
    @(negedge clk);
    check("resp_v_drop", rd.resp_v_o, 0);
    drain();

    // saturation on the 4-bit instance
    step();
    clear = 1'b1; step(); clear = 1'b0;
    use4 = 1'b1;
    v = 1'b1; instret = 1'b0; reason = 6'd1;
    repeat (20) step();
    v = 1'b0;
    @(negedge clk);
    check("sat_overflow4", ovf4, 1);
    check("sat_overflow32", ovf, 0);
    issue(6'd1, 15); issue(6'd34, 15);
    drain();
    clear = 1'b1; step(); clear = 1'b0;
    @(negedge clk);
    check("sat_clear_overflow4", ovf4, 0);
    issue(6'd1, 0);
    drain();
    use4 = 1'b0;

    // asynchronous reset during a held response
    v = 1'b1; instret = 1'b1;
    repeat (2) step();
    v = 1'b0;
    rd.resp_ready_i = 1'b0;
    issue(6'd34, 2);
    check("arst_pre_resp_v", rd.resp_v_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_resp_v", rd.resp_v_o, 0);
    check("arst_resp_data", rd.resp_data_o, 0);
    expq.delete();
    step();
    rst_n = 1'b1;
    rd.resp_ready_i = 1'b1;
    issue(6'd0, 0); issue(6'd33, 0); issue(6'd34, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
